// File: rtl/pin_capture.sv
// pin_capture: edge-capture front end for the icestick logic analyzer.
// Synchronizes the probe pins, stamps every change with a free-running cycle
// count and queues {pins, time, lost} records in a first-word fall-through
// FIFO that drains through a valid/ready port.
// Build macro: PINCAP_WRAP_EVT_EN adds a record (evt_wrap=1) at every
// timestamp wrap so the consumer can extend time past 2^TSW cycles.
module pin_capture #(
    parameter int unsigned NPINS = 7,
    parameter int unsigned TSW   = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NPINS-1:0] pin,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [NPINS-1:0] evt_pins,
    output logic [TSW-1:0]   evt_time,
    output logic             evt_lost,
    output logic             evt_wrap,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [NPINS-1:0] pins;
        logic [TSW-1:0]   stamp;
        logic             lost;
`ifdef PINCAP_WRAP_EVT_EN
        logic             wrap;
`endif
    } rec_t;

    // Startup: one warm-up edge, one edge that forces the initial record, then run
    typedef enum logic [1:0] {StWarm, StInit, StRun} start_e;

    logic [NPINS-1:0] s1_q;
    logic [NPINS-1:0] s2_q;
    logic [NPINS-1:0] last_q;
    logic [TSW-1:0]   ts_q;

    start_e state_q;
    start_e state_d;
    logic   force_init;
    logic   running;

    logic chg;
    logic wr_req;
    logic do_wr;
    logic do_rd;
    logic drop;
    rec_t wr_rec;
`ifdef PINCAP_WRAP_EVT_EN
    logic wrap_hit;
`endif

    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        empty;
    logic        full;
    rec_t        mem_q [DEPTH];
    rec_t        head;

    logic lost_pend_q;
    logic overflow_q;

    // Two-flop synchronizer; kept out of reset so it settles while reset is held
    always_ff @(posedge clk) begin
        s1_q <= pin;
        s2_q <= s1_q;
    end

    // Free-running timestamp, wraps silently from all-ones to zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TSW'(1);
        end
    end

    // Startup sequencer state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StWarm;
        end else begin
            state_q <= state_d;
        end
    end

    // Startup sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWarm:  state_d = StInit;
            StInit:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StWarm;
        endcase
    end

    // Startup sequencer outputs
    always_comb begin
        force_init = 1'b0;
        running    = 1'b0;
        case (state_q)
            StInit:  force_init = 1'b1;
            StRun:   running    = 1'b1;
            default: ;
        endcase
    end

    // Record request: forced initial record, pin change, or (optionally) wrap
    always_comb begin
        wr_rec       = '0;
        chg          = running && (s2_q != last_q);
        wr_req       = force_init || chg;
        wr_rec.pins  = s2_q;
        wr_rec.stamp = ts_q;
        wr_rec.lost  = lost_pend_q;
`ifdef PINCAP_WRAP_EVT_EN
        // ts_q reads zero only after a real wrap once the sequencer is running
        wrap_hit     = running && (ts_q == '0);
        wr_req       = force_init || chg || wrap_hit;
        wr_rec.wrap  = wrap_hit;
`endif
    end

    // FIFO status and transfer decisions; a read frees the slot a full write needs
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_rd = !empty && evt_ready;
        do_wr = wr_req && (!full || do_rd);
        drop  = wr_req && full && !do_rd;
    end

    // FIFO pointers; reset discards every queued record
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (do_rd) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by empty
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_rec;
        end
    end

    // Last recorded pin state and the drop bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q      <= '0;
            lost_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // last follows every change even when its record is dropped
            if (force_init || chg) begin
                last_q <= s2_q;
            end
            if (drop) begin
                lost_pend_q <= 1'b1;
                overflow_q  <= 1'b1;
            end else if (do_wr) begin
                lost_pend_q <= 1'b0;
            end
        end
    end

    // Head entry drives the port directly; fields read zero while empty
    always_comb begin
        head      = mem_q[rptr_q[AW-1:0]];
        evt_valid = !empty;
        evt_pins  = '0;
        evt_time  = '0;
        evt_lost  = 1'b0;
        evt_wrap  = 1'b0;
        overflow  = overflow_q;
        if (!empty) begin
            evt_pins = head.pins;
            evt_time = head.stamp;
            evt_lost = head.lost;
`ifdef PINCAP_WRAP_EVT_EN
            evt_wrap = head.wrap;
`endif
        end
    end

endmodule

// File: tb/tb_pin_capture.sv
// Bench for pin_capture with NPINS=7, TSW=8, DEPTH=4. Inputs change on the
// falling edge; a queue-based reference model is stepped once per rising edge.
module tb_pin_capture;

    localparam int NPINS = 7;
    localparam int TSW   = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NPINS-1:0] pin;
    logic             evt_ready;
    logic             evt_valid;
    logic [NPINS-1:0] evt_pins;
    logic [TSW-1:0]   evt_time;
    logic             evt_lost;
    logic             evt_wrap;
    logic             overflow;
    logic [18:0]      dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    pin_capture #(
        .NPINS(NPINS),
        .TSW  (TSW),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin      (pin),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_pins (evt_pins),
        .evt_time (evt_time),
        .evt_lost (evt_lost),
        .evt_wrap (evt_wrap),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    assign dut_vec = {evt_valid, evt_pins, evt_time, evt_lost, evt_wrap, overflow};

    // Reference model: a queue of records, a cycle count since reset and the
    // pin samples of the last two edges.
    typedef struct {
        logic [6:0] pins;
        logic [7:0] tstamp;
        logic       lost;
        logic       wrap;
    } rec_t;

    rec_t       m_q[$];
    logic [6:0] m_p1   = '0;
    logic [6:0] m_p2   = '0;
    logic [6:0] m_last = '0;
    int         m_n    = 0;
    logic       m_lost = 1'b0;
    logic       m_ovf  = 1'b0;

    function automatic void model_step();
        logic [6:0] s2v;
        logic       want;
        logic       wrapv;
        logic       rd;
        rec_t       r;
        s2v  = m_p2;
        m_p2 = m_p1;
        m_p1 = pin;
        if (!reset_n) begin
            m_q.delete();
            m_n    = 0;
            m_lost = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            rd    = (m_q.size() > 0) && evt_ready;
            want  = 1'b0;
            wrapv = 1'b0;
            if (m_n == 1) begin
                want = 1'b1;
            end else if (m_n >= 2) begin
                if (s2v != m_last) want = 1'b1;
`ifdef PINCAP_WRAP_EVT_EN
                if (m_n % 256 == 0) begin
                    want  = 1'b1;
                    wrapv = 1'b1;
                end
`endif
            end
            if (want) begin
                m_last   = s2v;
                r.pins   = s2v;
                r.tstamp = 8'(m_n);
                r.lost   = m_lost;
                r.wrap   = wrapv;
                if (m_q.size() < DEPTH || rd) begin
                    m_q.push_back(r);
                    m_lost = 1'b0;
                end else begin
                    m_lost = 1'b1;
                    m_ovf  = 1'b1;
                end
            end
            if (rd) void'(m_q.pop_front());
            m_n++;
        end
    endfunction

    function automatic logic [18:0] model_vec();
        if (m_q.size() == 0) return {1'b0, 7'h00, 8'h00, 1'b0, 1'b0, m_ovf};
        return {1'b1, m_q[0].pins, m_q[0].tstamp, m_q[0].lost, m_q[0].wrap, m_ovf};
    endfunction

    // One clock: model the coming rising edge, then wait for the falling edge
    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    // Reset with pins p, then let the initial record be consumed
    task automatic do_reset(input logic [6:0] p);
        pin       = p;
        evt_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic test_reset_idle();
        int busy = 0;
        pin       = 7'h08;
        evt_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (4) cyc();
        n_checks++;
        if (dut_vec !== 19'h0)
            $display("FAIL reset_state: got %h want %h", dut_vec, 19'h0);
        reset_n = 1'b1;
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0)
            $display("FAIL init_first_edge_valid: got %b want 0", evt_valid);
        if (evt_valid !== 1'b0) n_fail++;
        cyc();
        n_checks++;
        if ({evt_valid, evt_pins, evt_time, evt_lost} !== {1'b1, 7'h08, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL init_record: got %h want %h",
                     {evt_valid, evt_pins, evt_time, evt_lost}, {1'b1, 7'h08, 8'd1, 1'b0});
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL init_model: got %h want %h", dut_vec, model_vec());
        end
        repeat (1000) begin
            cyc();
            if (evt_valid) busy++;
        end
`ifndef PINCAP_WRAP_EVT_EN
        n_checks++;
        if (busy != 0) begin
            n_fail++;
            $display("FAIL idle_no_records: got %0d valid cycles want 0", busy);
        end
`endif
    endtask

    task automatic test_single_edge();
        int t;
        do_reset(7'h08);
        t   = m_n % 256;
        pin = 7'h09;
        cyc();
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_early_valid: got %b want 0", evt_valid);
        end
        cyc();
        n_checks++;
        if ({evt_valid, evt_pins, evt_time, evt_lost} !== {1'b1, 7'h09, 8'(t + 2), 1'b0}) begin
            n_fail++;
            $display("FAIL edge_record: got %h want %h",
                     {evt_valid, evt_pins, evt_time, evt_lost}, {1'b1, 7'h09, 8'(t + 2), 1'b0});
        end
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_consumed: got %b want 0", evt_valid);
        end
    endtask

    task automatic test_burst_backpressure();
        int         t;
        logic [6:0] ep;
        do_reset(7'h09);
        evt_ready = 1'b0;
        t         = m_n % 256;
        for (int i = 0; i < 6; i++) begin
            pin[1] = ~pin[1];
            cyc();
        end
        repeat (3) cyc();
        n_checks++;
        if ({evt_valid, overflow} !== 2'b11) begin
            n_fail++;
            $display("FAIL burst_overflow: got %b want 11", {evt_valid, overflow});
        end
        for (int i = 0; i < 4; i++) begin
            ep = (i % 2 == 0) ? 7'h0B : 7'h09;
            n_checks++;
            if ({evt_valid, evt_pins, evt_time, evt_lost} !== {1'b1, ep, 8'(t + 2 + i), 1'b0}) begin
                n_fail++;
                $display("FAIL burst_drain_%0d: got %h want %h", i,
                         {evt_valid, evt_pins, evt_time, evt_lost}, {1'b1, ep, 8'(t + 2 + i), 1'b0});
            end
            evt_ready = 1'b1;
            cyc();
        end
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_empty: got %b want 0", evt_valid);
        end
        evt_ready = 1'b0;
        pin       = 7'h0D;
        t         = m_n % 256;
        repeat (3) cyc();
        n_checks++;
        if (dut_vec !== {1'b1, 7'h0D, 8'(t + 2), 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL lost_flag_set: got %h want %h", dut_vec,
                     {1'b1, 7'h0D, 8'(t + 2), 1'b1, 1'b0, 1'b1});
        end
        evt_ready = 1'b1;
        pin       = 7'h09;
        t         = m_n % 256;
        repeat (3) cyc();
        n_checks++;
        if (dut_vec !== {1'b1, 7'h09, 8'(t + 2), 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL lost_flag_clear: got %h want %h", dut_vec,
                     {1'b1, 7'h09, 8'(t + 2), 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_full_simul_read();
        int         t;
        logic [6:0] ep [4];
        ep[0] = 7'h00;
        ep[1] = 7'h08;
        ep[2] = 7'h00;
        ep[3] = 7'h10;
        do_reset(7'h00);
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pin[3] = ~pin[3];
            cyc();
        end
        repeat (3) cyc();
        n_checks++;
        if ({evt_valid, evt_pins, overflow} !== {1'b1, 7'h08, 1'b0}) begin
            n_fail++;
            $display("FAIL full_head: got %h want %h", {evt_valid, evt_pins, overflow},
                     {1'b1, 7'h08, 1'b0});
        end
        pin[4] = 1'b1;
        t      = m_n % 256;
        cyc();
        cyc();
        evt_ready = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({evt_valid, evt_pins, evt_lost, overflow} !== {1'b1, ep[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL full_rd_wr_%0d: got %h want %h", i,
                         {evt_valid, evt_pins, evt_lost, overflow}, {1'b1, ep[i], 1'b0, 1'b0});
            end
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL full_model_%0d: got %h want %h", i, dut_vec, model_vec());
            end
            if (i == 3) begin
                n_checks++;
                if (evt_time !== 8'(t + 2)) begin
                    n_fail++;
                    $display("FAIL full_new_time: got %h want %h", evt_time, 8'(t + 2));
                end
            end
            cyc();
        end
        n_checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_no_overflow: got %b want 00", {evt_valid, overflow});
        end
    endtask

`ifdef PINCAP_WRAP_EVT_EN
    task automatic test_wrap();
        int seen = 0;
        do_reset(7'h01);
        while (m_n < 600) begin
            cyc();
            if (evt_valid) begin
                seen++;
                n_checks++;
                if ({evt_pins, evt_time, evt_wrap} !== {7'h01, 8'h00, 1'b1}) begin
                    n_fail++;
                    $display("FAIL wrap_record: got %h want %h", {evt_pins, evt_time, evt_wrap},
                             {7'h01, 8'h00, 1'b1});
                end
            end
        end
        n_checks++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 2", seen);
        end
        while (m_n < 766) cyc();
        pin = 7'h03;
        repeat (3) cyc();
        n_checks++;
        if (dut_vec !== {1'b1, 7'h03, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_combined: got %h want %h", dut_vec,
                     {1'b1, 7'h03, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_single: got %b want 0", evt_valid);
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        do_reset(7'h00);
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin[5] = ~pin[5];
            cyc();
        end
        repeat (3) cyc();
        n_checks++;
        if (evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_queued: got %b want 1", evt_valid);
        end
        reset_n = 1'b0;
        cyc();
        n_checks++;
        if (dut_vec !== 19'h0) begin
            n_fail++;
            $display("FAIL midrst_cleared: got %h want %h", dut_vec, 19'h0);
        end
        reset_n = 1'b1;
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_first_edge: got %b want 0", evt_valid);
        end
        cyc();
        n_checks++;
        if (dut_vec !== {1'b1, 7'h20, 8'd1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_init: got %h want %h", dut_vec,
                     {1'b1, 7'h20, 8'd1, 1'b0, 1'b0, 1'b0});
        end
        evt_ready = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_single: got %b want 0", evt_valid);
        end
    endtask

    task automatic test_random();
        int b;
        int lowp = 0;
        do_reset(7'($urandom_range(0, 127)));
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec, model_vec());
            end
            if (i % 64 == 0) lowp = $urandom_range(0, 1);
            evt_ready = lowp != 0 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                b      = $urandom_range(0, NPINS - 1);
                pin[b] = ~pin[b];
            end
            cyc();
        end
    endtask

    initial begin
        test_reset_idle();
        test_single_edge();
        test_burst_backpressure();
        test_full_simul_read();
`ifdef PINCAP_WRAP_EVT_EN
        test_wrap();
`endif
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
